// File: rtl/bp_me_wormhole_flit_serializer.sv
// bp_me_wormhole_flit_serializer
//
// Purpose: takes one full wormhole packet {payload, length, y_cord, x_cord}
// per handshake and sends it onto a wormhole router link as fixed-width
// flits, least significant flit first. Flit 0 carries the routing header
// (x_cord, y_cord, length), so the router can route and count the worm.
// When the last flit of a worm is accepted in the same cycle as a new
// packet, the next worm starts without a bubble.
//
// Ports:
//   clk_i          single clock
//   reset_i        synchronous, active-high reset
//   packet_i       packet to serialize (header in the LSBs)
//   v_i            packet_i valid
//   ready_o        serializer accepts a packet this cycle
//   link_data_o    current flit
//   link_v_o       link_data_o valid
//   link_ready_i   router accepts the flit this cycle
//   debug_state_o  FSM state (0 = IDLE, 1 = SEND)
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid & ready are both high. A producer that raises valid keeps
// valid and data steady until that edge. ready_o depends combinationally
// on link_ready_i (only while sending); link_v_o and link_data_o come
// from registered state only.

module bp_me_wormhole_flit_serializer #(
  parameter int packet_width_p = 100,
  parameter int flit_width_p   = 34,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 1,
  parameter int len_width_p    = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [packet_width_p-1:0] packet_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [flit_width_p-1:0]   link_data_o,
  output logic                      link_v_o,
  input  logic                      link_ready_i,
  output logic [0:0]                debug_state_o
);

  localparam int num_flits_lp    = (packet_width_p + flit_width_p - 1) / flit_width_p;
  localparam int stored_width_lp = num_flits_lp * flit_width_p;
  localparam int len_span_lp     = 1 << len_width_p;
  localparam int cnt_span_lp     = (num_flits_lp > len_span_lp) ? num_flits_lp : len_span_lp;
  localparam int cnt_width_lp    = (cnt_span_lp > 2) ? $clog2(cnt_span_lp) : 1;
  localparam int len_lsb_lp      = x_cord_width_p + y_cord_width_p;

  localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(num_flits_lp - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]                 r_state;
  logic [stored_width_lp-1:0] r_data;
  logic [cnt_width_lp-1:0]    r_len;
  logic [cnt_width_lp-1:0]    r_cnt;

  logic                       w_send;
  logic                       w_last;
  logic                       w_ready;
  logic                       w_pkt_hs;
  logic                       w_flit_hs;
  logic [flit_width_p-1:0]    w_flit;

  assign w_send    = (r_state == ST_SEND);
  assign w_last    = (r_cnt == r_len);
  // While sending, a new packet is only taken when the final flit is
  // leaving this very cycle, which gives back-to-back worms with no gap.
  assign w_ready   = ~reset_i & (~w_send | (w_last & link_ready_i));
  assign w_pkt_hs  = v_i & w_ready;
  assign w_flit_hs = w_send & link_ready_i;

  // Flit select. Counter values past the stored data (a length field that
  // overstates the packet) yield an all-zero flit.
  always_comb begin
    w_flit = '0;
    for (int i = 0; i < num_flits_lp; i++) begin
      if (r_cnt == cnt_width_lp'(i)) begin
        w_flit = r_data[i*flit_width_p +: flit_width_p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pkt_hs) begin
            r_data  <= stored_width_lp'(packet_i);
            r_len   <= cnt_width_lp'(packet_i[len_lsb_lp +: len_width_p]);
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_flit_hs) begin
            if (!w_last) begin
              r_cnt <= r_cnt + cnt_width_lp'(1);
            end else if (w_pkt_hs) begin
              r_data  <= stored_width_lp'(packet_i);
              r_len   <= cnt_width_lp'(packet_i[len_lsb_lp +: len_width_p]);
              r_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o       = w_ready;
  assign link_v_o      = w_send;
  assign link_data_o   = w_flit;
  assign debug_state_o = r_state;

  // A worm longer than the stored packet is an upstream formatting error.
  a_len_fits: assert property (@(posedge clk_i) disable iff (reset_i)
    w_send |-> (r_len <= last_idx_lp));

endmodule
